ysyx_22050854_imem_resp: RTL
============================

YSYX_22050854_IMEM_RESP -- requirements
Module: ysyx_22050854_imem_resp

Interface
REQ-001 SHALL have parameter LATENCY, default 2, cycles from request accept to resp_valid (legal range 1..15).
REQ-002 SHALL have parameter DEPTH, default 1024, number of 32-bit instruction words.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h8000_0000, byte address of word 0.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  fetch request present.
REQ-007 SHALL have port req_ready  output  1  responder can accept a request.
REQ-008 SHALL have port req_pc  input  32  byte address of the instruction to fetch.
REQ-009 SHALL have port resp_valid  output  1  response held on resp_inst/resp_err.
REQ-010 SHALL have port resp_ready  input  1  CPU accepts the response.
REQ-011 SHALL have port resp_inst  output  32  fetched instruction word.
REQ-012 SHALL have port resp_err  output  1  fetch fault (misaligned or out of range).
REQ-013 SHALL have port load_en  input  1  preload write strobe.
REQ-014 SHALL have port load_addr  input  log2(DEPTH)  word index for the preload write.
REQ-015 SHALL have port load_data  input  32  preload write data.
REQ-016 SHALL have port fetch_count  output  32  number of completed response handshakes.

Function
REQ-017 SHALL implement states IDLE, WAIT, RESP; req_ready = 1 only in IDLE and not in reset.
REQ-018 SHALL accept a request when req_valid && req_ready, latch req_pc, and move IDLE->WAIT (LATENCY>1) or IDLE->RESP (LATENCY=1).
REQ-019 SHALL count LATENCY-1 cycles in WAIT, then enter RESP, so resp_valid rises exactly LATENCY cycles after the accept edge.
REQ-020 SHALL sample the memory word at the accept cycle; a load_en to the same word in that same cycle SHALL NOT affect this response (old data returned).
REQ-021 SHALL compute word index = (req_pc - BASE_ADDR) >> 2, using 32-bit unsigned subtraction with wrap.
REQ-022 SHALL set resp_err = 1 and resp_inst = 32'h0 when req_pc[1:0] != 0 or the word index >= DEPTH (this includes req_pc < BASE_ADDR via wrap).
REQ-023 SHALL hold resp_valid, resp_inst and resp_err stable in RESP until resp_ready = 1.
REQ-024 SHALL, on resp_valid && resp_ready, return to IDLE, drop resp_valid next cycle, and increment fetch_count by 1.
REQ-025 SHALL let fetch_count wrap from 32'hFFFF_FFFF to 0.
REQ-026 SHALL count error responses in fetch_count like normal ones.
REQ-027 SHALL NOT accept a new request in the cycle a response handshake completes; the next accept is possible the following cycle (one request in flight maximum).
REQ-028 SHALL perform load_en writes at the clock edge in any state, including during WAIT/RESP, without disturbing the latched response.
REQ-029 SHALL ignore req_pc, req_valid and resp_ready changes outside the states where they are sampled.

Reset
REQ-030 SHALL, while rst = 1, force state IDLE, req_ready 0, resp_valid 0, resp_inst 0, resp_err 0, latency counter 0, fetch_count 0.
REQ-031 SHALL abandon any in-flight request on reset mid-WAIT or mid-RESP without counting it.
REQ-032 SHALL NOT reset memory contents; preloaded words survive rst.
REQ-033 SHALL raise req_ready in the first cycle after rst deasserts.

Verification
REQ-034 Preload word 0 = 32'h0010_0093, LATENCY=2, request pc 0x8000_0000 with resp_ready=1 -> resp_valid 2 cycles after accept, resp_inst 0x0010_0093, resp_err 0, fetch_count 1.
REQ-035 Request pc 0x8000_0002 -> resp_err 1, resp_inst 0; request pc 0x8000_1000 (DEPTH=1024) -> resp_err 1; request pc 0x7FFF_FFFC -> resp_err 1.
REQ-036 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and data stable, req_ready 0 throughout; release -> one handshake, fetch_count +1.
REQ-037 In the accept cycle, load_en to the same word with 32'hDEAD_BEEF over old 32'h0000_0073 -> response 0x0000_0073; the next fetch of that word -> 0xDEAD_BEEF.
REQ-038 Assert rst during WAIT -> next cycle resp_valid 0, fetch_count 0; after release, req_ready 1 and a fresh fetch completes normally.
REQ-039 Back-to-back requests with LATENCY=1 and resp_ready=1 -> one completed fetch every 2 cycles; start fetch_count at 32'hFFFF_FFFF (after 2^32-1 fetches, or by forcing the counter in simulation) -> wraps to 0.

Source files
------------

// File: rtl/ysyx_22050854_imem_resp.sv
// Instruction-memory responder: one fetch in flight, fixed LATENCY from accept to resp_valid,
// preloadable word array, alignment/range fault detection and a completed-fetch counter.
module ysyx_22050854_imem_resp #(
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_pc,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [31:0]              resp_inst,
    output logic                     resp_err,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [31:0]              load_data,
    output logic [31:0]              fetch_count
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  lat_q, lat_d;
    logic [31:0] inst_q, inst_d;
    logic        err_q, err_d;
    logic [31:0] cnt_q, cnt_d;

    logic [31:0] mem_q [DEPTH];

    logic [31:0] offset;
    logic        addr_err;
    logic [31:0] rd_word;

    // Preload port writes in every state; memory is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem_q[load_addr] <= load_data;
        end
    end

    // Addresses below BASE_ADDR wrap to huge offsets and fall out of range.
    always_comb begin
        offset   = req_pc - BASE_ADDR;
        addr_err = (req_pc[1:0] != 2'b00) || ({2'b00, offset[31:2]} >= DEPTH);
        rd_word  = mem_q[offset[AW+1:2]];
    end

    assign req_ready   = !rst && (state_q == IDLE);
    assign resp_valid  = !rst && (state_q == RESP);
    assign resp_inst   = rst ? 32'h0 : inst_q;
    assign resp_err    = !rst && err_q;
    assign fetch_count = rst ? 32'h0 : cnt_q;

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        inst_d  = inst_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    inst_d = addr_err ? 32'h0 : rd_word;
                    err_d  = addr_err;
                    if (LATENCY > 1) begin
                        state_d = WAIT;
                        lat_d   = 4'(LATENCY - 1);
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (lat_q <= 4'd1) begin
                    state_d = RESP;
                    lat_d   = 4'd0;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    cnt_d   = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lat_q   <= 4'd0;
            inst_q  <= 32'h0;
            err_q   <= 1'b0;
            cnt_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
